// File: rtl/non_restoring_sqrt_v2_0.sv
// Sequential non-restoring integer square root: one root bit per cycle,
// one sign-fix cycle, then a valid/ready held result.
module non_restoring_sqrt_v2_0 #(
  parameter int unsigned inout_width = 16,
  parameter int unsigned round_mode  = 0
) (
  input  logic                       aclk,
  input  logic                       reset,
  input  logic [2*inout_width-1:0]   radicand,
  input  logic                       i_data_valid,
  output logic                       i_data_ready,
  output logic [inout_width-1:0]     root,
  output logic [inout_width:0]       remainder,
  output logic                       round_sat,
  output logic                       o_data_valid,
  input  logic                       o_data_ready
);

  localparam int unsigned W     = inout_width;
  localparam int unsigned RW    = W + 2;
  localparam int unsigned IDX_W = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [2*W-1:0]   rad_q, rad_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [W-1:0]     q_q, q_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     root_q, root_d;
  logic [W:0]       rem_out_q, rem_out_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;

  logic ready_c, load_c, step_c, fix_c, release_c;

  // State register
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_data_valid)        state_d = S_CALC;
      S_CALC: if (idx_q == IDX_W'(0))  state_d = S_FIX;
      S_FIX:                           state_d = S_DONE;
      S_DONE: if (o_data_ready)        state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // Control strobes decoded from the state
  always_comb begin
    ready_c   = 1'b0;
    step_c    = 1'b0;
    fix_c     = 1'b0;
    release_c = 1'b0;
    unique case (state_q)
      S_IDLE:  ready_c   = 1'b1;
      S_CALC:  step_c    = 1'b1;
      S_FIX:   fix_c     = 1'b1;
      S_DONE:  release_c = o_data_ready;
      default: ready_c   = 1'b0;
    endcase
  end

  assign load_c       = ready_c & i_data_valid;
  assign i_data_ready = ready_c;

  logic [RW-1:0] rem_shift_c, rem_step_c;
  logic [W:0]    rem_fix_c;
  logic          round_up_c, q_all_ones_c;

  // One non-restoring step; the remainder sign selects subtract or add
  assign rem_shift_c  = {rem_q[W-1:0], rad_q[2*W-1 -: 2]};
  assign rem_step_c   = rem_q[RW-1] ? (rem_shift_c + {q_q, 2'b11})
                                    : (rem_shift_c - {q_q, 2'b01});
  // Final remainder is non-negative and at most 2q, so W+1 bits hold it
  assign rem_fix_c    = rem_q[RW-1] ? (rem_q[W:0] + {q_q, 1'b1}) : rem_q[W:0];
  assign round_up_c   = (round_mode == 1) && (rem_fix_c > {1'b0, q_q});
  assign q_all_ones_c = &q_q;

  always_comb begin
    rad_d     = rad_q;
    rem_d     = rem_q;
    q_d       = q_q;
    idx_d     = idx_q;
    root_d    = root_q;
    rem_out_d = rem_out_q;
    sat_d     = sat_q;
    valid_d   = valid_q;

    if (load_c) begin
      rad_d = radicand;
      rem_d = '0;
      q_d   = '0;
      idx_d = IDX_W'(W - 1);
    end

    if (step_c) begin
      rad_d = {rad_q[2*W-3:0], 2'b00};
      rem_d = rem_step_c;
      q_d   = {q_q[W-2:0], ~rem_step_c[RW-1]};
      idx_d = idx_q - IDX_W'(1);
    end

    if (fix_c) begin
      if (round_up_c && !q_all_ones_c) begin
        root_d = q_q + W'(1);
      end else begin
        root_d = q_q;
      end
      rem_out_d = rem_fix_c;
      sat_d     = round_up_c && q_all_ones_c;
      valid_d   = 1'b1;
    end

    if (release_c) begin
      valid_d = 1'b0;
    end
  end

  // Datapath and result registers
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      rad_q     <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      idx_q     <= '0;
      root_q    <= '0;
      rem_out_q <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      idx_q     <= idx_d;
      root_q    <= root_d;
      rem_out_q <= rem_out_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
    end
  end

  assign root         = root_q;
  assign remainder    = rem_out_q;
  assign round_sat    = sat_q;
  assign o_data_valid = valid_q;

endmodule

// File: tb/tb_non_restoring_sqrt_v2_0.sv
// Bench for non_restoring_sqrt_v2_0: three instances (W16 floor, W16 round,
// W8 floor) share stimulus and are checked every cycle against a transaction model.
module tb_non_restoring_sqrt_v2_0;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] radicand = '0;
  logic        i_data_valid = 1'b0;
  logic        o_data_ready = 1'b0;

  always #5 aclk = ~aclk;

  logic        rdy0, vld0, sat0, rdy1, vld1, sat1, rdy2, vld2, sat2;
  logic [15:0] root0, root1;
  logic [16:0] rem0, rem1;
  logic [7:0]  root2;
  logic [8:0]  rem2;

  non_restoring_sqrt_v2_0 #(.inout_width(16), .round_mode(0)) u_w16_floor (
    .aclk(aclk), .reset(reset), .radicand(radicand), .i_data_valid(i_data_valid),
    .i_data_ready(rdy0), .root(root0), .remainder(rem0), .round_sat(sat0),
    .o_data_valid(vld0), .o_data_ready(o_data_ready));

  non_restoring_sqrt_v2_0 #(.inout_width(16), .round_mode(1)) u_w16_round (
    .aclk(aclk), .reset(reset), .radicand(radicand), .i_data_valid(i_data_valid),
    .i_data_ready(rdy1), .root(root1), .remainder(rem1), .round_sat(sat1),
    .o_data_valid(vld1), .o_data_ready(o_data_ready));

  non_restoring_sqrt_v2_0 #(.inout_width(8), .round_mode(0)) u_w8_floor (
    .aclk(aclk), .reset(reset), .radicand(radicand[15:0]), .i_data_valid(i_data_valid),
    .i_data_ready(rdy2), .root(root2), .remainder(rem2), .round_sat(sat2),
    .o_data_valid(vld2), .o_data_ready(o_data_ready));

  logic        d_ready [3];
  logic        d_valid [3];
  logic        d_sat   [3];
  logic [15:0] d_root  [3];
  logic [16:0] d_rem   [3];

  always_comb begin
    d_ready[0] = rdy0; d_valid[0] = vld0; d_sat[0] = sat0; d_root[0] = root0; d_rem[0] = rem0;
    d_ready[1] = rdy1; d_valid[1] = vld1; d_sat[1] = sat1; d_root[1] = root1; d_rem[1] = rem1;
    d_ready[2] = rdy2; d_valid[2] = vld2; d_sat[2] = sat2;
    d_root[2]  = {8'd0, root2};
    d_rem[2]   = {8'd0, rem2};
  end

  function automatic int kw(input int k);
    return (k == 2) ? 8 : 16;
  endfunction

  function automatic int kr(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  // Floor root by greedy bit search on squares
  function automatic longint unsigned isqrt(input longint unsigned n, input int w);
    longint unsigned r, t;
    r = 0;
    for (int b = w - 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= n) r = t;
    end
    return r;
  endfunction

  function automatic longint unsigned exp_root(input longint unsigned n, input int w, input int rm);
    longint unsigned r;
    r = isqrt(n, w);
    if (rm == 1 && (n - r * r) > r && r != (64'd1 << w) - 1) return r + 1;
    return r;
  endfunction

  function automatic logic exp_sat(input longint unsigned n, input int w, input int rm);
    longint unsigned r;
    r = isqrt(n, w);
    return (rm == 1) && ((n - r * r) > r) && (r == (64'd1 << w) - 1);
  endfunction

  // Transaction-level model: accept, wait W+1 edges, hold until released
  logic            m_busy  [3];
  logic            m_valid [3];
  logic            m_sat   [3];
  int              m_cnt   [3];
  longint unsigned m_op    [3];
  logic [15:0]     m_root  [3];
  logic [16:0]     m_rem   [3];

  always @(posedge aclk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_busy[k] <= 1'b0; m_valid[k] <= 1'b0; m_sat[k] <= 1'b0;
        m_cnt[k] <= 0; m_op[k] <= 0; m_root[k] <= '0; m_rem[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_valid[k]) begin
          if (o_data_ready) m_valid[k] <= 1'b0;
        end else if (m_busy[k]) begin
          m_cnt[k] <= m_cnt[k] + 1;
          if (m_cnt[k] + 1 == kw(k) + 1) begin
            m_busy[k]  <= 1'b0;
            m_valid[k] <= 1'b1;
            m_root[k]  <= 16'(exp_root(m_op[k], kw(k), kr(k)));
            m_rem[k]   <= 17'(m_op[k] - isqrt(m_op[k], kw(k)) * isqrt(m_op[k], kw(k)));
            m_sat[k]   <= exp_sat(m_op[k], kw(k), kr(k));
          end
        end else if (i_data_valid) begin
          m_busy[k] <= 1'b1;
          m_cnt[k]  <= 0;
          m_op[k]   <= 64'(radicand) & ((64'd1 << (2 * kw(k))) - 1);
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input int k, input longint unsigned got,
                     input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", name, k, $time, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] op, output int lat16, output int lat8);
    radicand = op;
    i_data_valid = 1'b1;
    @(posedge aclk); #2;
    i_data_valid = 1'b0;
    radicand = $urandom;
    lat16 = -1;
    lat8  = -1;
    for (int n = 1; n <= 40 && lat16 < 0; n++) begin
      @(posedge aclk); #2;
      if (vld2 && lat8 < 0) lat8 = n;
      if (vld0) lat16 = n;
    end
    if (lat16 < 0) cmp("valid_timeout", 0, 0, 1);
  endtask

  task automatic release_op(input int hold);
    for (int i = 0; i < hold; i++) begin
      radicand = $urandom;
      i_data_valid = 1'($urandom_range(0, 1));
      @(posedge aclk); #2;
    end
    i_data_valid = 1'b0;
    o_data_ready = 1'b1;
    @(posedge aclk); #2;
    o_data_ready = 1'b0;
  endtask

  logic [31:0] rop;
  int          l16, l8, sel, sq;

  initial begin
    cmp("model_isqrt_144", 0, isqrt(64'd144, 16), 64'd12);
    cmp("model_round_6", 1, exp_root(64'd6, 16, 1), 64'd2);
    cmp("model_round_8", 1, exp_root(64'd8, 16, 1), 64'd3);
    cmp("model_sat_max", 1, 64'(exp_sat(64'hFFFF_FFFF, 16, 1)), 64'd1);

    @(posedge aclk);
    fork
      forever begin
        @(negedge aclk);
        for (int k = 0; k < 3; k++) begin
          cmp("i_data_ready", k, 64'(d_ready[k]), 64'(!m_busy[k] && !m_valid[k]));
          cmp("o_data_valid", k, 64'(d_valid[k]), 64'(m_valid[k]));
          cmp("root", k, 64'(d_root[k]), 64'(m_root[k]));
          cmp("remainder", k, 64'(d_rem[k]), 64'(m_rem[k]));
          cmp("round_sat", k, 64'(d_sat[k]), 64'(m_sat[k]));
        end
      end
    join_none

    repeat (2) @(posedge aclk);
    #2;
    cmp("reset_ready", 0, 64'(rdy0), 1);
    cmp("reset_valid", 0, 64'(vld0), 0);
    cmp("reset_root", 0, 64'(root0), 0);
    reset = 1'b0;

    start_op(32'd144, l16, l8);
    cmp("lat_w16_144", 0, 64'(l16), 17);
    cmp("lat_w8_144", 2, 64'(l8), 9);
    cmp("root_144", 0, 64'(root0), 12);
    cmp("rem_144", 0, 64'(rem0), 0);
    release_op(0);

    start_op(32'd0, l16, l8);
    cmp("lat_w16_zero", 0, 64'(l16), 17);
    cmp("root_zero", 0, 64'(root0), 0);
    cmp("rem_zero", 0, 64'(rem0), 0);
    release_op(1);

    start_op(32'hFFFF_FFFF, l16, l8);
    cmp("root_max", 0, 64'(root0), 64'hFFFF);
    cmp("rem_max", 0, 64'(rem0), 64'h1FFFE);
    cmp("sat_floor_max", 0, 64'(sat0), 0);
    cmp("root_round_max", 1, 64'(root1), 64'hFFFF);
    cmp("sat_round_max", 1, 64'(sat1), 1);
    release_op(0);

    start_op(32'd8, l16, l8);
    cmp("root_round_8", 1, 64'(root1), 3);
    cmp("root_floor_8", 0, 64'(root0), 2);
    release_op(0);

    start_op(32'd6, l16, l8);
    cmp("root_round_6", 1, 64'(root1), 2);
    cmp("rem_round_6", 1, 64'(rem1), 2);
    release_op(0);

    // Back-pressure: results held, new operand ignored while DONE
    start_op(32'd1000, l16, l8);
    for (int i = 0; i < 5; i++) begin
      radicand = 32'h1234_5678;
      i_data_valid = 1'b1;
      @(posedge aclk); #2;
    end
    cmp("hold_root", 0, 64'(root0), 31);
    cmp("hold_rem", 0, 64'(rem0), 39);
    cmp("hold_ready", 0, 64'(rdy0), 0);
    cmp("hold_valid", 0, 64'(vld0), 1);
    i_data_valid = 1'b0;
    o_data_ready = 1'b1;
    @(posedge aclk); #2;
    o_data_ready = 1'b0;
    cmp("release_valid", 0, 64'(vld0), 0);
    cmp("release_ready", 0, 64'(rdy0), 1);

    // Reset during the sixth CALC cycle
    radicand = 32'd12345678;
    i_data_valid = 1'b1;
    @(posedge aclk); #2;
    i_data_valid = 1'b0;
    repeat (6) @(posedge aclk);
    #2;
    reset = 1'b1;
    @(posedge aclk); #2;
    cmp("abort_valid", 0, 64'(vld0), 0);
    cmp("abort_ready", 0, 64'(rdy0), 1);
    reset = 1'b0;
    start_op(32'd1000000, l16, l8);
    cmp("root_1e6", 0, 64'(root0), 1000);
    cmp("rem_1e6", 0, 64'(rem0), 0);
    release_op(2);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 3);
      sq  = $urandom_range(0, 65535);
      case (sel)
        0:       rop = $urandom;
        1:       rop = $urandom & 32'h0000_FFFF;
        2:       rop = 32'(sq * sq);
        default: rop = 32'(sq * sq) - 32'd1;
      endcase
      start_op(rop, l16, l8);
      cmp("lat_w16_rand", 0, 64'(l16), 17);
      cmp("lat_w8_rand", 2, 64'(l8), 9);
      release_op($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge aclk);
      #2;
    end

    repeat (2) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/non_restoring_sqrt_v2_0.md
NON_RESTORING_SQRT_V2_0 -- requirements
Module: non_restoring_sqrt_v2_0

Interface
REQ-001 SHALL have parameter: inout_width, 16, root width W (>=2); radicand width is 2W.
REQ-002 SHALL have parameter: round_mode, 0, 0 = floor root, 1 = round-to-nearest root.
REQ-003 SHALL have port: aclk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: radicand  input  2W  unsigned operand.
REQ-006 SHALL have port: i_data_valid  input  1  operand present.
REQ-007 SHALL have port: i_data_ready  output  1  block accepts an operand.
REQ-008 SHALL have port: root  output  W  result root.
REQ-009 SHALL have port: remainder  output  W+1  radicand minus floor-root squared.
REQ-010 SHALL have port: round_sat  output  1  rounding saturated at all-ones.
REQ-011 SHALL have port: o_data_valid  output  1  result present.
REQ-012 SHALL have port: o_data_ready  input  1  downstream accepts the result.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-014 SHALL drive i_data_ready high only in IDLE, as a combinational decode of the state.
REQ-015 SHALL accept an operand on the edge where i_data_valid && i_data_ready, register it, clear the partial root and remainder, load iteration index W-1, and enter CALC.
REQ-016 SHALL, in CALC, do one non-restoring step per cycle: shift in the next 2 radicand bits (MSB first); if rem>=0 then rem = (rem<<2|bits) - (q<<2|01), else rem = (rem<<2|bits) + (q<<2|11); then q = (q<<1) | (new rem >= 0).
REQ-017 SHALL hold the internal remainder signed at W+2 bits, so no step overflows.
REQ-018 SHALL leave CALC for FIX after exactly W CALC cycles (index 0 processed).
REQ-019 SHALL, in FIX (one cycle), add (q<<1|1) to rem if rem<0; result: floor root q, remainder 0..2q.
REQ-020 SHALL, in FIX with round_mode=1, output q+1 if final remainder > q; if q is all-ones, output all-ones and set round_sat=1; remainder always reports the floor-root remainder.
REQ-021 SHALL, in FIX with round_mode=0, output q and hold round_sat at 0.
REQ-022 SHALL register root, remainder and round_sat on the FIX edge and set o_data_valid=1 there, entering DONE.
REQ-023 SHALL set fixed latency: o_data_valid rises W+1 clock edges after the accepting edge, independent of the operand value (zero included).
REQ-024 SHALL, in DONE, hold root, remainder, round_sat and o_data_valid stable until o_data_ready=1 is sampled.
REQ-025 SHALL, on that edge, clear o_data_valid and return to IDLE, so the next operand is accepted one cycle later at the earliest.
REQ-026 SHALL ignore i_data_valid and radicand changes outside IDLE.
REQ-027 SHALL treat radicand=0 as a normal operand (root 0, remainder 0, no error output).

Reset
REQ-028 SHALL, when reset is asserted at any time (including mid-CALC or in DONE), immediately abort the operation and enter IDLE, discarding the in-flight operand.
REQ-029 SHALL, during reset, drive root=0, remainder=0, round_sat=0, o_data_valid=0, i_data_ready=1, and clear the internal registers.
REQ-030 SHALL accept an operand on the first rising edge after reset deasserts.

Verification
REQ-031 SHALL pass, W=16, round_mode=0: radicand 144 -> root 12, remainder 0; o_data_valid at edge 17 after acceptance.
REQ-032 SHALL pass, W=16: radicand 0 -> root 0, remainder 0, same 17-edge latency; radicand 0xFFFFFFFF -> root 0xFFFF, remainder 0x1FFFE.
REQ-033 SHALL pass, W=16, round_mode=1: 8 -> root 3; 6 -> root 2 (remainder 2, not >2); 0xFFFFFFFF -> root 0xFFFF, round_sat=1.
REQ-034 SHALL pass: o_data_ready held low 5 cycles after o_data_valid -> outputs stable, i_data_ready=0, new operand ignored; results released on the edge o_data_ready=1.
REQ-035 SHALL pass: reset pulsed at CALC cycle 6 -> o_data_valid stays 0, i_data_ready=1; next operand 1000000 -> root 1000, remainder 0.
REQ-036 SHALL pass: random 2W-bit operands -> root^2 <= radicand < (root+1)^2 and remainder = radicand - root^2 (round_mode=0), at W=16 and W=8.
